// File: rtl/serial_to_parallel_rx.sv
// rtl/serial_to_parallel_rx.sv - serial bit stream to WIDTH-bit parallel words with sync alignment
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   din, din_en       serial bit, sampled only when din_en=1
//   sync              marks din as bit 0 of a word (only when din_en=1)
//   dout, dout_valid  last completed word and its valid flag
//   dout_ready        consumer accepts dout when dout_valid=1
//   busy, bit_cnt     partial word in progress / bits received so far
//   overrun, sync_err sticky error flags, cleared by err_clr
module serial_to_parallel_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din,
  input  logic                     din_en,
  input  logic                     sync,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  output logic                     sync_err,
  input  logic                     err_clr
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    HUNT    = 1'b0,
    ALIGNED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             sync_err_q, sync_err_d;

  // Working values for the bit being accepted this cycle.
  logic             take;
  logic [WIDTH-1:0] sh_base;
  logic [CW-1:0]    cnt_base;
  logic             complete;
  logic             ovr_set;
  logic             serr_set;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !dout_ready;
    take         = 1'b0;
    sh_base      = sh_q;
    cnt_base     = bit_cnt_q;
    complete     = 1'b0;
    ovr_set      = 1'b0;
    serr_set     = 1'b0;

    // In HUNT only a sync-marked bit is accepted; in ALIGNED every enabled bit is.
    take = din_en && ((state_q == ALIGNED) || sync);

    if (take) begin
      // A sync restarts the word: the partial contents are thrown away and
      // this bit is counted as bit 0.
      if (sync) begin
        sh_base  = '0;
        cnt_base = '0;
        serr_set = (state_q == ALIGNED) && (bit_cnt_q != '0);
      end

      if (MSB_FIRST) begin
        sh_d = {sh_base[WIDTH-2:0], din};
      end else begin
        sh_d = {din, sh_base[WIDTH-1:1]};
      end

      state_d  = ALIGNED;
      complete = (cnt_base == LAST_BIT);

      if (complete) begin
        bit_cnt_d = '0;
        // The output slot is free if empty or being consumed on this same edge.
        if (!dout_valid_q || dout_ready) begin
          dout_d       = sh_d;
          dout_valid_d = 1'b1;
        end else begin
          ovr_set = 1'b1;
        end
      end else begin
        bit_cnt_d = cnt_base + CW'(1);
      end
    end

    busy_d = (bit_cnt_d != '0);

    // A set on the same edge as err_clr wins.
    overrun_d  = (overrun_q && !err_clr) || ovr_set;
    sync_err_d = (sync_err_q && !err_clr) || serr_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign bit_cnt    = bit_cnt_q;
  assign overrun    = overrun_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// tb/tb_serial_to_parallel_rx.sv - directed bench for serial_to_parallel_rx (MSB-first and LSB-first)
module tb_serial_to_parallel_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_en;
  logic       sync;
  logic       dout_ready;
  logic       err_clr;

  logic [3:0] m_dout, l_dout;
  logic       m_valid, l_valid;
  logic       m_busy, l_busy;
  logic [1:0] m_cnt, l_cnt;
  logic       m_ovr, l_ovr;
  logic       m_serr, l_serr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_to_parallel_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_en     (din_en),
    .sync       (sync),
    .dout       (m_dout),
    .dout_valid (m_valid),
    .dout_ready (dout_ready),
    .busy       (m_busy),
    .bit_cnt    (m_cnt),
    .overrun    (m_ovr),
    .sync_err   (m_serr),
    .err_clr    (err_clr)
  );

  serial_to_parallel_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_en     (din_en),
    .sync       (sync),
    .dout       (l_dout),
    .dout_valid (l_valid),
    .dout_ready (dout_ready),
    .busy       (l_busy),
    .bit_cnt    (l_cnt),
    .overrun    (l_ovr),
    .sync_err   (l_serr),
    .err_clr    (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    din    = b;
    sync   = s;
    din_en = 1'b1;
    tick();
    din_en = 1'b0;
    sync   = 1'b0;
    din    = 1'b0;
  endtask

  // Sends w[3] first; sync only on the first bit when s=1.
  task automatic send_word(input logic [3:0] w, input logic s);
    for (int i = 3; i >= 0; i--) begin
      send_bit(w[i], (i == 3) ? s : 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_en = 1'b0; sync = 1'b0;
    dout_ready = 1'b1; err_clr = 1'b0;
    tick(); tick();
    check("rst_dout",   {28'd0, m_dout}, 32'h0);
    check("rst_valid",  m_valid, 0);
    check("rst_cnt",    m_cnt, 0);
    check("rst_busy",   m_busy, 0);
    check("rst_ovr",    m_ovr, 0);
    check("rst_serr",   m_serr, 0);
    rst = 1'b0;
    tick();

    // Basic word 1,0,1,1 with sync on the first bit.
    send_bit(1'b1, 1'b1);
    check("basic_cnt1", m_cnt, 1);
    check("basic_busy1", m_busy, 1);
    check("basic_valid_early", m_valid, 0);
    send_bit(1'b0, 1'b0);
    check("basic_cnt2", m_cnt, 2);
    send_bit(1'b1, 1'b0);
    check("basic_cnt3", m_cnt, 3);
    send_bit(1'b1, 1'b0);
    check("basic_cnt0", m_cnt, 0);
    check("basic_busy0", m_busy, 0);
    check("basic_valid", m_valid, 1);
    check("basic_dout", m_dout, 4'b1011);
    check("basic_lsb_dout", l_dout, 4'b1101);
    tick();
    check("basic_valid_one_cycle", m_valid, 0);

    // Streaming second word, no sync.
    send_word(4'b0111, 1'b0);
    check("stream_valid", m_valid, 1);
    check("stream_dout", m_dout, 4'b0111);
    check("stream_lsb_dout", l_dout, 4'b1110);
    tick();
    check("stream_valid_clr", l_valid, 0);

    // Gapped enable, sync at bit_cnt=0 in ALIGNED is legal.
    send_bit(1'b0, 1'b1);
    check("gap_serr_legal", m_serr, 0);
    for (int i = 0; i < 3; i++) tick();
    check("gap_cnt_hold", m_cnt, 1);
    check("gap_busy_hold", m_busy, 1);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("gap_cnt_hold2", m_cnt, 2);
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("gap_cnt_hold3", m_cnt, 3);
    check("gap_valid_none", m_valid, 0);
    send_bit(1'b1, 1'b0);
    check("gap_dout", m_dout, 4'b0111);
    check("gap_valid", m_valid, 1);
    tick();

    // Backpressure: transfer coinciding with completion, then overrun.
    dout_ready = 1'b0;
    send_word(4'b1010, 1'b0);
    check("bp_dout1", m_dout, 4'b1010);
    check("bp_lsb_dout1", l_dout, 4'b0101);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("bp_stable", m_dout, 4'b1010);
    check("bp_valid_hold", m_valid, 1);
    dout_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    check("same_edge_dout", m_dout, 4'b0101);
    check("same_edge_valid", m_valid, 1);
    check("same_edge_ovr", m_ovr, 0);
    dout_ready = 1'b0;
    send_word(4'b1100, 1'b0);
    check("ovr_flag", m_ovr, 1);
    check("ovr_lsb_flag", l_ovr, 1);
    check("ovr_dout_kept", m_dout, 4'b0101);
    check("ovr_cnt_wrap", m_cnt, 0);
    dout_ready = 1'b1;
    tick();
    check("ovr_xfer_valid", m_valid, 0);
    check("ovr_sticky", m_ovr, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr_clr", m_ovr, 0);

    // Realign mid-word.
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("realign_cnt2", m_cnt, 2);
    send_bit(1'b0, 1'b1);
    check("realign_serr", m_serr, 1);
    check("realign_cnt1", m_cnt, 1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    check("realign_dout", m_dout, 4'b0011);
    check("realign_lsb_dout", l_dout, 4'b1100);
    check("realign_valid", m_valid, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("serr_clr", m_serr, 0);

    // Reset mid-word, then HUNT discards unsynced bits.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_cnt", m_cnt, 0);
    check("rstmid_busy", m_busy, 0);
    send_word(4'b1111, 1'b0);
    check("hunt_cnt", m_cnt, 0);
    check("hunt_valid", m_valid, 0);
    check("hunt_dout", m_dout, 4'h0);

    // Reset with a pending word.
    dout_ready = 1'b0;
    send_word(4'b1001, 1'b1);
    check("pend_dout", m_dout, 4'b1001);
    check("pend_valid", m_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstpend_valid", m_valid, 0);
    check("rstpend_dout", m_dout, 4'h0);
    send_word(4'b0101, 1'b0);
    check("rstpend_hunt_valid", m_valid, 0);
    check("rstpend_hunt_cnt", m_cnt, 0);
    send_word(4'b0110, 1'b1);
    check("resync_dout", m_dout, 4'b0110);
    check("resync_valid", m_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
